// File: rtl/prog_word_assembler.sv
// prog_word_assembler
//
// Builds 32-bit program words out of a byte stream (UART receiver or SPI
// slave byte path), tags each word with a running word index and queues the
// pairs in a small FIFO for a downstream programmer. A reserved marker word
// ends the program; once the FIFO has drained the block reports done.
//
// Optional feature macro: PROG_CHECKSUM_EN
//   When defined, the word after the marker is taken as an XOR checksum over
//   every word that was actually queued, and a mismatch raises csum_err_o.
//   When undefined, csum_err_o is tied low and the marker drains directly.
//
// Ports
//   clk_i          single clock, rising edge
//   rst_i          synchronous active-high reset
//   rx_dv_i        one-cycle strobe qualifying rx_byte_i
//   rx_byte_i      received byte
//   word_valid_o   FIFO head valid
//   word_ready_i   consumer takes the head when high together with valid
//   word_o         FIFO head data
//   addr_o         word index paired with word_o
//   done_o         sticky: marker seen and FIFO drained
//   err_timeout_o  one-cycle pulse: partial word discarded after idle timeout
//   overflow_o     sticky: a word was dropped because the FIFO was full
//   csum_err_o     sticky: checksum mismatch (checksum build only)

module prog_word_assembler #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned TIMEOUT_CYC = 50000,
  parameter logic [31:0] DONE_WORD   = 32'h0000_0FFF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        rx_dv_i,
  input  logic [7:0]  rx_byte_i,
  output logic        word_valid_o,
  input  logic        word_ready_i,
  output logic [31:0] word_o,
  output logic [13:0] addr_o,
  output logic        done_o,
  output logic        err_timeout_o,
  output logic        overflow_o,
  output logic        csum_err_o
);

  localparam int unsigned PtrW  = $clog2(DEPTH);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned IdleW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [IdleW-1:0] IdleLast = IdleW'(TIMEOUT_CYC - 1);
  localparam logic [CntW-1:0]  FifoCap  = CntW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2,
    DONE    = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        byteCnt_q, byteCnt_d;
  logic [23:0]       assembly_q, assembly_d;
  logic [IdleW-1:0]  idleCnt_q, idleCnt_d;
  logic              stageValid_q, stageValid_d;
  logic [31:0]       stageWord_q, stageWord_d;
  logic [13:0]       wordCnt_q, wordCnt_d;
  logic [PtrW-1:0]   wrPtr_q, wrPtr_d;
  logic [PtrW-1:0]   rdPtr_q, rdPtr_d;
  logic [CntW-1:0]   fifoCount_q, fifoCount_d;
  logic              done_q, done_d;
  logic              errTimeout_q, errTimeout_d;
  logic              overflow_q, overflow_d;
`ifdef PROG_CHECKSUM_EN
  logic              csumPhase_q, csumPhase_d;
  logic              csumErr_q, csumErr_d;
  logic [31:0]       csumAcc_q, csumAcc_d;
`endif

  // Each entry carries the word index in the upper bits and the data below.
  logic [45:0]       fifoMem_q [DEPTH];
  logic [45:0]       headEntry;

  logic [31:0]       fullWord;
  logic              fifoFull;
  logic              fifoEmpty;
  logic              popEn;
  logic              pushEn;
  logic              dropEn;

  // The fourth byte is never stored in the assembly register; it is combined
  // on the fly so a finished word can be classified in the cycle it arrives.
  assign fullWord  = {rx_byte_i, assembly_q};
  assign fifoFull  = (fifoCount_q == FifoCap);
  assign fifoEmpty = (fifoCount_q == '0);
  assign popEn     = !fifoEmpty && word_ready_i;
  // A full FIFO still accepts the staged word when the head leaves this cycle.
  assign pushEn    = stageValid_q && (!fifoFull || popEn);
  assign dropEn    = stageValid_q && fifoFull && !popEn;

  // Byte collection and control FSM next state. Bytes are only listened to
  // in IDLE and COLLECT; a completed ordinary word goes to a one-entry
  // staging register and is written to the FIFO on the following cycle.
  always_comb begin
    state_d      = state_q;
    byteCnt_d    = byteCnt_q;
    assembly_d   = assembly_q;
    idleCnt_d    = idleCnt_q;
    stageValid_d = 1'b0;
    stageWord_d  = stageWord_q;
    done_d       = done_q;
    errTimeout_d = 1'b0;
`ifdef PROG_CHECKSUM_EN
    csumPhase_d  = csumPhase_q;
    csumErr_d    = csumErr_q;
`endif
    if (state_q == IDLE || state_q == COLLECT) begin
      if (rx_dv_i) begin
        idleCnt_d = '0;
        if (byteCnt_q == 2'd3) begin
          byteCnt_d  = '0;
          assembly_d = '0;
          state_d    = IDLE;
`ifdef PROG_CHECKSUM_EN
          if (csumPhase_q) begin
            csumPhase_d = 1'b0;
            if (fullWord != csumAcc_q) begin
              csumErr_d = 1'b1;
            end
            state_d = DRAIN;
          end else if (fullWord == DONE_WORD) begin
            csumPhase_d = 1'b1;
          end else begin
            stageValid_d = 1'b1;
            stageWord_d  = fullWord;
          end
`else
          if (fullWord == DONE_WORD) begin
            state_d = DRAIN;
          end else begin
            stageValid_d = 1'b1;
            stageWord_d  = fullWord;
          end
`endif
        end else begin
          byteCnt_d = byteCnt_q + 2'd1;
          state_d   = COLLECT;
          case (byteCnt_q)
            2'd0:    assembly_d[7:0]   = rx_byte_i;
            2'd1:    assembly_d[15:8]  = rx_byte_i;
            default: assembly_d[23:16] = rx_byte_i;
          endcase
        end
      end else if (state_q == COLLECT) begin
        // A stalled sender must not leave half a word waiting forever; the
        // checksum wait flag is untouched so that wait simply resumes.
        if (idleCnt_q == IdleLast) begin
          byteCnt_d    = '0;
          assembly_d   = '0;
          idleCnt_d    = '0;
          errTimeout_d = 1'b1;
          state_d      = IDLE;
        end else begin
          idleCnt_d = idleCnt_q + IdleW'(1);
        end
      end
    end else if (state_q == DRAIN) begin
      if (fifoEmpty && !stageValid_q) begin
        state_d = DONE;
        done_d  = 1'b1;
      end
    end
  end

  // FIFO bookkeeping: pointers, occupancy, word index and the sticky
  // overflow flag. Only words that really enter the FIFO advance the index.
  always_comb begin
    wrPtr_d     = wrPtr_q + PtrW'(pushEn);
    rdPtr_d     = rdPtr_q + PtrW'(popEn);
    fifoCount_d = fifoCount_q + CntW'(pushEn) - CntW'(popEn);
    wordCnt_d   = wordCnt_q + 14'(pushEn);
    overflow_d  = overflow_q | dropEn;
`ifdef PROG_CHECKSUM_EN
    csumAcc_d   = pushEn ? (csumAcc_q ^ stageWord_q) : csumAcc_q;
`endif
  end

  // All control state, including the FSM, is registered here with a
  // synchronous reset that throws away any buffered data.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      byteCnt_q    <= '0;
      assembly_q   <= '0;
      idleCnt_q    <= '0;
      stageValid_q <= 1'b0;
      stageWord_q  <= '0;
      wordCnt_q    <= '0;
      wrPtr_q      <= '0;
      rdPtr_q      <= '0;
      fifoCount_q  <= '0;
      done_q       <= 1'b0;
      errTimeout_q <= 1'b0;
      overflow_q   <= 1'b0;
`ifdef PROG_CHECKSUM_EN
      csumPhase_q  <= 1'b0;
      csumErr_q    <= 1'b0;
      csumAcc_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      byteCnt_q    <= byteCnt_d;
      assembly_q   <= assembly_d;
      idleCnt_q    <= idleCnt_d;
      stageValid_q <= stageValid_d;
      stageWord_q  <= stageWord_d;
      wordCnt_q    <= wordCnt_d;
      wrPtr_q      <= wrPtr_d;
      rdPtr_q      <= rdPtr_d;
      fifoCount_q  <= fifoCount_d;
      done_q       <= done_d;
      errTimeout_q <= errTimeout_d;
      overflow_q   <= overflow_d;
`ifdef PROG_CHECKSUM_EN
      csumPhase_q  <= csumPhase_d;
      csumErr_q    <= csumErr_d;
      csumAcc_q    <= csumAcc_d;
`endif
    end
  end

  // FIFO storage needs no reset: the pointers and count define what is live.
  always_ff @(posedge clk_i) begin
    if (!rst_i && pushEn) begin
      fifoMem_q[wrPtr_q] <= {wordCnt_q, stageWord_q};
    end
  end

  // The head is hidden during a reset cycle so no handshake can complete
  // against data that is about to be discarded.
  assign headEntry     = fifoMem_q[rdPtr_q];
  assign word_valid_o  = !fifoEmpty && !rst_i;
  assign word_o        = word_valid_o ? headEntry[31:0] : 32'h0;
  assign addr_o        = word_valid_o ? headEntry[45:32] : 14'h0;
  assign done_o        = done_q;
  assign err_timeout_o = errTimeout_q;
  assign overflow_o    = overflow_q;
`ifdef PROG_CHECKSUM_EN
  assign csum_err_o    = csumErr_q;
`else
  assign csum_err_o    = 1'b0;
`endif

endmodule

// File: tb/tb_prog_word_assembler.sv
// tb_prog_word_assembler
//
// Scoreboarded bench for prog_word_assembler. Stimulus tasks feed bytes into
// the DUT and into a byte-level reference model that decides which words
// should appear and with which index; a monitor process compares whatever
// the DUT hands out against the queue the model filled.

`timescale 1ns/1ps

module tb_prog_word_assembler;

  localparam int unsigned DEPTH     = 4;
  localparam int unsigned TIMEOUT   = 16;
  localparam logic [31:0] DONE_WORD = 32'h0000_0FFF;
`ifdef PROG_CHECKSUM_EN
  localparam bit CsumEn = 1'b1;
`else
  localparam bit CsumEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rxDv = 1'b0;
  logic [7:0]  rxByte = 8'h00;
  logic        ready = 1'b0;
  logic        wordValid;
  logic [31:0] wordOut;
  logic [13:0] addrOut;
  logic        done;
  logic        errTimeout;
  logic        overflow;
  logic        csumErr;

  int errCount = 0;
  int checkCount = 0;

  // Reference model state
  logic [45:0] expQ[$];
  logic [7:0]  partial[$];
  int          sinceByte = 0;
  logic [13:0] modelCnt = '0;
  int          modelOcc = 0;
  bit          modelFinished = 1'b0;
  bit          modelCsumWait = 1'b0;
  logic [31:0] modelXor = '0;
  bit          expCsumErr = 1'b0;
  int          expTimeouts = 0;

  // Monitor observations
  int          obsTimeouts = 0;
  int          validCycles = 0;
  bit          holdPending = 1'b0;
  logic [31:0] holdWord = '0;
  logic [13:0] holdAddr = '0;
  bit          prevDone = 1'b0;

  // 0: ready held low, 1: ready held high, 2: random but never low 3 in a row
  int          readyMode = 1;
  int          readyLowRun = 0;

  always #5 clk = ~clk;

  prog_word_assembler #(
    .DEPTH(DEPTH),
    .TIMEOUT_CYC(TIMEOUT),
    .DONE_WORD(DONE_WORD)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .rx_dv_i(rxDv),
    .rx_byte_i(rxByte),
    .word_valid_o(wordValid),
    .word_ready_i(ready),
    .word_o(wordOut),
    .addr_o(addrOut),
    .done_o(done),
    .err_timeout_o(errTimeout),
    .overflow_o(overflow),
    .csum_err_o(csumErr)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic modelReset();
    expQ.delete();
    partial.delete();
    sinceByte     = 0;
    modelCnt      = '0;
    modelOcc      = 0;
    modelFinished = 1'b0;
    modelCsumWait = 1'b0;
    modelXor      = '0;
    expCsumErr    = 1'b0;
    expTimeouts   = 0;
  endtask

  // Word-level rules: marker ends collection, a full FIFO (only possible
  // while ready is held low) drops the word, anything else gets the next index.
  task automatic modelWord(input logic [31:0] w);
    if (modelCsumWait) begin
      modelCsumWait = 1'b0;
      modelFinished = 1'b1;
      if (w != modelXor) expCsumErr = 1'b1;
    end else if (w == DONE_WORD) begin
      if (CsumEn) modelCsumWait = 1'b1;
      else modelFinished = 1'b1;
    end else if (readyMode == 0 && modelOcc >= DEPTH) begin
      // dropped: index and checksum unchanged
    end else begin
      expQ.push_back({modelCnt, w});
      modelCnt = modelCnt + 14'd1;
      modelXor = modelXor ^ w;
      if (readyMode == 0) modelOcc++;
    end
  endtask

  task automatic driveCycle(input bit dv, input logic [7:0] b);
    logic [31:0] w;
    @(posedge clk);
    #1;
    rxDv   = dv;
    rxByte = dv ? b : 8'($urandom);
    case (readyMode)
      0: ready = 1'b0;
      1: ready = 1'b1;
      default: begin
        if (readyLowRun >= 2) ready = 1'b1;
        else ready = 1'($urandom_range(0, 1));
      end
    endcase
    readyLowRun = ready ? 0 : readyLowRun + 1;
    if (dv) begin
      sinceByte = 0;
      if (!modelFinished) begin
        partial.push_back(b);
        if (partial.size() == 4) begin
          w = {partial[3], partial[2], partial[1], partial[0]};
          partial.delete();
          modelWord(w);
        end
      end
    end else begin
      sinceByte++;
      if (!modelFinished && partial.size() > 0 && sinceByte == TIMEOUT) begin
        partial.delete();
        expTimeouts++;
      end
    end
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) driveCycle(1'b0, 8'h00);
  endtask

  task automatic applyStimulus(input logic [7:0] b, input int gap);
    idleCycles(gap);
    driveCycle(1'b1, b);
  endtask

  task automatic sendWord(input logic [31:0] w, input int gapMax);
    applyStimulus(w[7:0],   $urandom_range(0, gapMax));
    applyStimulus(w[15:8],  $urandom_range(0, gapMax));
    applyStimulus(w[23:16], $urandom_range(0, gapMax));
    applyStimulus(w[31:24], $urandom_range(0, gapMax));
  endtask

  task automatic setReady(input int mode);
    readyMode = mode;
    modelOcc  = 0;
  endtask

  task automatic resetDut();
    @(posedge clk);
    #1;
    rst  = 1'b1;
    rxDv = 1'b0;
    modelReset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    obsTimeouts = 0;
  endtask

  task automatic waitDrain(input int maxCycles);
    int n = 0;
    while (expQ.size() != 0 && n < maxCycles) begin
      driveCycle(1'b0, 8'h00);
      n++;
    end
    checkOutput("drainWithinBound", expQ.size(), 0);
    idleCycles(3);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_valid"},    wordValid,  0);
    checkOutput({tag, "_word"},     wordOut,    0);
    checkOutput({tag, "_addr"},     addrOut,    0);
    checkOutput({tag, "_done"},     done,       0);
    checkOutput({tag, "_timeout"},  errTimeout, 0);
    checkOutput({tag, "_overflow"}, overflow,   0);
    checkOutput({tag, "_csumErr"},  csumErr,    0);
  endtask

  // Monitor: every handshake pops the scoreboard, stalled heads must hold
  // still, timeout pulses are counted and done must not precede the drain.
  always @(negedge clk) begin
    logic [45:0] exp;
    if (rst) begin
      holdPending = 1'b0;
      prevDone    = 1'b0;
    end else begin
      if (errTimeout) obsTimeouts++;
      if (wordValid) validCycles++;
      if (holdPending) begin
        checkOutput("holdValid", wordValid, 1);
        checkOutput("holdWord",  wordOut,   holdWord);
        checkOutput("holdAddr",  addrOut,   holdAddr);
      end
      holdPending = wordValid && !ready;
      holdWord    = wordOut;
      holdAddr    = addrOut;
      if (wordValid && ready) begin
        if (expQ.size() == 0) begin
          checkCount++;
          errCount++;
          $display("[TB] FAIL unexpectedWord: got word %0h addr %0h, expected none", wordOut, addrOut);
        end else begin
          exp = expQ.pop_front();
          checkOutput("word", wordOut, exp[31:0]);
          checkOutput("addr", addrOut, exp[45:32]);
        end
      end
      if (done && !prevDone) checkOutput("doneAfterDrain", expQ.size(), 0);
      prevDone = done;
    end
  end

  // Hard stop in case something hangs outside the bounded waits.
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios interleaved with a randomized word stream.
  initial begin
    logic [31:0] w;
    int validBefore;

    // Reset state
    modelReset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkAllZero("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single word, consumer always ready
    $display("[TB] single word");
    setReady(1);
    validCycles = 0;
    applyStimulus(8'h78, 0);
    applyStimulus(8'h56, 0);
    applyStimulus(8'h34, 0);
    applyStimulus(8'h12, 0);
    idleCycles(6);
    checkOutput("singleValidCycles", validCycles, 1);
    checkOutput("singleDrained", expQ.size(), 0);

    // Random words with a stalling consumer
    $display("[TB] random stream");
    setReady(2);
    for (int i = 0; i < 40; i++) begin
      w = $urandom;
      if (w == DONE_WORD) w = w ^ 32'h1;
      sendWord(w, 3);
    end
    setReady(1);
    waitDrain(200);
    checkOutput("randomNoOverflow", overflow, 0);
    checkOutput("randomTimeouts", obsTimeouts, expTimeouts);

    // Idle timeout discards a partial word; one cycle short does not
    $display("[TB] timeout");
    resetDut();
    setReady(1);
    applyStimulus(8'hAA, 0);
    applyStimulus(8'hBB, 0);
    idleCycles(TIMEOUT);
    applyStimulus(8'h01, 0);
    applyStimulus(8'h02, 0);
    applyStimulus(8'h03, TIMEOUT - 1);
    applyStimulus(8'h04, 0);
    waitDrain(50);
    checkOutput("timeoutPulses", obsTimeouts, expTimeouts);
    checkOutput("timeoutModelCount", expTimeouts, 1);

    // Overflow with the consumer stalled, then drain in order
    $display("[TB] overflow");
    resetDut();
    setReady(0);
    for (int i = 0; i < 6; i++) begin
      w = $urandom;
      if (w == DONE_WORD) w = w ^ 32'h1;
      sendWord(w, 1);
    end
    idleCycles(4);
    checkOutput("overflowSet", overflow, 1);
    checkOutput("overflowHeadValid", wordValid, 1);
    checkOutput("overflowQueued", expQ.size(), DEPTH);
    setReady(1);
    waitDrain(50);
    checkOutput("overflowSticky", overflow, 1);

    // End-of-program marker
    $display("[TB] marker");
    resetDut();
    setReady(1);
    sendWord(32'h0000_0011, 2);
    sendWord(32'h0000_0022, 2);
    sendWord(DONE_WORD, 2);
    if (CsumEn) sendWord(modelXor, 2);
    for (int n = 0; n < 100 && !done; n++) idleCycles(1);
    @(negedge clk);
    checkOutput("markerDone", done, 1);
    checkOutput("markerCsumErr", csumErr, expCsumErr);
    validBefore = validCycles;
    sendWord(32'h5566_7788, 0);
    sendWord($urandom, 1);
    idleCycles(6);
    checkOutput("ignoredAfterDone", validCycles, validBefore);
    checkOutput("doneSticky", done, 1);

`ifdef PROG_CHECKSUM_EN
    // Wrong checksum
    $display("[TB] bad checksum");
    resetDut();
    setReady(1);
    sendWord(32'h0000_0011, 1);
    sendWord(32'h0000_0022, 1);
    sendWord(DONE_WORD, 1);
    sendWord(32'h0000_0034, 1);
    for (int n = 0; n < 100 && !done; n++) idleCycles(1);
    @(negedge clk);
    checkOutput("badCsumDone", done, 1);
    checkOutput("badCsumErr", csumErr, 1);
    checkOutput("badCsumModel", expCsumErr, 1);
`endif

    // Reset with queued words and a partial word
    $display("[TB] reset mid-stream");
    resetDut();
    setReady(0);
    for (int i = 0; i < 3; i++) begin
      w = $urandom;
      if (w == DONE_WORD) w = w ^ 32'h1;
      sendWord(w, 0);
    end
    applyStimulus(8'hC1, 0);
    applyStimulus(8'hC2, 0);
    idleCycles(2);
    checkOutput("preResetValid", wordValid, 1);
    @(posedge clk);
    #1;
    rst  = 1'b1;
    rxDv = 1'b0;
    modelReset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    obsTimeouts = 0;
    @(negedge clk);
    checkAllZero("midReset");
    setReady(1);
    sendWord(32'hCAFE_F00D, 1);
    waitDrain(50);

    checkOutput("finalTimeouts", obsTimeouts, expTimeouts);
    checkOutput("finalQueueEmpty", expQ.size(), 0);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
